// File: rtl/smem_result_writer_pkg.sv
// rtl/smem_result_writer_pkg.sv - shared constants, record field offsets, FSM states and record packer
package smem_result_writer_pkg;

    localparam int CL             = 512;
    localparam int READ_NUM_WIDTH = 8;
    localparam int MAX_READ       = 256;
    localparam int REC_W          = 256;

    localparam int X0_LSB    = 0;
    localparam int X1_LSB    = 64;
    localparam int X2_LSB    = 128;
    localparam int INFO_LSB  = 192;
    localparam int INFO_W    = 48;
    localparam int RNUM_LSB  = 240;
    localparam int VALID_BIT = 255;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    // info[63:48] is zero by construction, so only the low 48 bits are stored.
    function automatic logic [REC_W-1:0] pack_record(
        input logic [63:0]               x0,
        input logic [63:0]               x1,
        input logic [63:0]               x2,
        input logic [INFO_W-1:0]         info,
        input logic [READ_NUM_WIDTH-1:0] rnum
    );
        logic [REC_W-1:0] r;
        r                                = '0;
        r[X0_LSB +: 64]                  = x0;
        r[X1_LSB +: 64]                  = x1;
        r[X2_LSB +: 64]                  = x2;
        r[INFO_LSB +: INFO_W]            = info;
        r[RNUM_LSB +: READ_NUM_WIDTH]    = rnum;
        r[VALID_BIT]                     = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/smem_result_writer_line_fifo.sv
// rtl/smem_result_writer_line_fifo.sv - line FIFO with registered head and occupancy count
module line_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop   = pop_i && (count_q != '0);
    assign do_push  = push_i && ((count_q != DEPTH_C) || do_pop);
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);
    assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
    assign wr_ptr_d = wr_ptr_q + AW'(do_push);

    // The next head is the pushed line when nothing older survives this edge.
    always_comb begin
        head_d = '0;
        if (count_d != '0) begin
            if (do_push && (count_q == CW'(do_pop))) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

endmodule

// File: rtl/smem_result_writer.sv
// rtl/smem_result_writer.sv - packs SMEM result records into cache lines; SMEM_RESULT_CHECK_EN enables format checks
module smem_result_writer
    import smem_result_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SKID  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [8:0]                batch_size,
    input  logic                      result_valid,
    input  logic [READ_NUM_WIDTH-1:0] result_read_num,
    input  logic [63:0]               result_ik_x0,
    input  logic [63:0]               result_ik_x1,
    input  logic [63:0]               result_ik_x2,
    input  logic [63:0]               result_ik_info,
    input  logic                      read_done,
    input  logic [READ_NUM_WIDTH-1:0] read_done_num,
    output logic                      stall_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CL-1:0]             out_data,
    output logic [15:0]               lines_written,
    output logic                      all_done,
    output logic                      overflow,
    output logic                      err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SKID_C  = CW'(SKID);

    state_e           state_q, state_d;
    logic [8:0]       batch_q, batch_d;
    logic [8:0]       done_cnt_q, done_cnt_d;
    logic [REC_W-1:0] slot0_q, slot0_d;
    logic             slot0_vld_q, slot0_vld_d;
    logic [15:0]      lines_q, lines_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;

    logic [REC_W-1:0] rec;
    logic [CL-1:0]    push_line;
    logic             push, pop, can_push;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;

    assign rec      = pack_record(result_ik_x0, result_ik_x1, result_ik_x2,
                                  result_ik_info[INFO_W-1:0], result_read_num);
    assign pop      = out_valid && out_ready;
    assign can_push = !fifo_full || pop;

`ifdef SMEM_RESULT_CHECK_EN
    logic [MAX_READ-1:0] bitmap_q, bitmap_d;
    logic                dup_done, range_bad, info_bad;

    assign dup_done  = bitmap_q[read_done_num];
    assign range_bad = ({1'b0, read_done_num} >= batch_q);
    assign info_bad  = |result_ik_info[63:INFO_W];
`else
    logic unused_chk;
    assign unused_chk = ^{result_ik_info[63:INFO_W], read_done_num};
`endif

    always_comb begin
        state_d     = state_q;
        batch_d     = batch_q;
        done_cnt_d  = done_cnt_q;
        slot0_d     = slot0_q;
        slot0_vld_d = slot0_vld_q;
        lines_d     = lines_q + {15'd0, pop};
        overflow_d  = overflow_q;
        err_d       = err_q;
        push        = 1'b0;
        push_line   = '0;
`ifdef SMEM_RESULT_CHECK_EN
        bitmap_d    = bitmap_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    batch_d    = batch_size;
                    done_cnt_d = '0;
                    lines_d    = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
`ifdef SMEM_RESULT_CHECK_EN
                    bitmap_d   = '0;
`endif
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (result_valid) begin
                    if (slot0_vld_q) begin
                        push        = 1'b1;
                        push_line   = {rec, slot0_q};
                        slot0_d     = '0;
                        slot0_vld_d = 1'b0;
                    end else begin
                        slot0_d     = rec;
                        slot0_vld_d = 1'b1;
                    end
`ifdef SMEM_RESULT_CHECK_EN
                    if (info_bad) err_d = 1'b1;
`endif
                end
                if (read_done) begin
`ifdef SMEM_RESULT_CHECK_EN
                    if (range_bad) err_d = 1'b1;
                    if (dup_done) begin
                        err_d = 1'b1;
                    end else begin
                        bitmap_d[read_done_num] = 1'b1;
                        done_cnt_d              = done_cnt_q + 9'd1;
                    end
`else
                    done_cnt_d = done_cnt_q + 9'd1;
`endif
                end
                // The updated count is compared so a record arriving with the
                // final read_done is already in slot0 when FLUSH runs.
                if (done_cnt_d == batch_q) state_d = FLUSH;
            end
            FLUSH: begin
                if (!slot0_vld_q) begin
                    state_d = DRAIN;
                end else if (can_push) begin
                    push        = 1'b1;
                    push_line   = {{REC_W{1'b0}}, slot0_q};
                    slot0_d     = '0;
                    slot0_vld_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (push && !can_push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            batch_q     <= '0;
            done_cnt_q  <= '0;
            slot0_q     <= '0;
            slot0_vld_q <= 1'b0;
            lines_q     <= '0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            batch_q     <= batch_d;
            done_cnt_q  <= done_cnt_d;
            slot0_q     <= slot0_d;
            slot0_vld_q <= slot0_vld_d;
            lines_q     <= lines_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
        end
    end

`ifdef SMEM_RESULT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bitmap_q <= '0;
        end else begin
            bitmap_q <= bitmap_d;
        end
    end
`endif

    line_fifo #(
        .W     (CL),
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_line),
        .pop_i       (pop),
        .head_o      (out_data),
        .valid_o     (out_valid),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign stall_out     = ((DEPTH_C - fifo_count) <= SKID_C) || (state_q == FLUSH);
    assign lines_written = lines_q;
    assign all_done      = (state_q == DONE);
    assign overflow      = overflow_q;
`ifdef SMEM_RESULT_CHECK_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_smem_result_writer.sv
// tb/tb_smem_result_writer.sv - directed bench for smem_result_writer (with or without SMEM_RESULT_CHECK_EN)
module tb_smem_result_writer;

`ifdef SMEM_RESULT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   batch_size = '0;
    logic         result_valid = 1'b0;
    logic [7:0]   result_read_num = '0;
    logic [63:0]  result_ik_x0 = '0, result_ik_x1 = '0, result_ik_x2 = '0, result_ik_info = '0;
    logic         read_done = 1'b0;
    logic [7:0]   read_done_num = '0;
    logic         stall_out, out_valid, all_done, overflow, err;
    logic         out_ready = 1'b0;
    logic [511:0] out_data;
    logic [15:0]  lines_written;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    smem_result_writer #(.DEPTH(4), .SKID(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .batch_size(batch_size),
        .result_valid(result_valid), .result_read_num(result_read_num),
        .result_ik_x0(result_ik_x0), .result_ik_x1(result_ik_x1),
        .result_ik_x2(result_ik_x2), .result_ik_info(result_ik_info),
        .read_done(read_done), .read_done_num(read_done_num),
        .stall_out(stall_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .lines_written(lines_written), .all_done(all_done),
        .overflow(overflow), .err(err)
    );

    typedef struct {
        logic        st;
        logic [8:0]  bs;
        logic        rv;
        logic [63:0] x0;
        logic        rd;
        logic        rdy;
        logic        e_valid;
        logic        e_stall;
        logic        e_done;
        logic [15:0] e_lines;
    } vec_t;

    function automatic vec_t mkv(input logic st, input logic [8:0] bs, input logic rv,
                                 input logic [63:0] x0, input logic rd, input logic rdy,
                                 input logic ev, input logic es, input logic ed,
                                 input logic [15:0] el);
        vec_t v;
        v.st = st; v.bs = bs; v.rv = rv; v.x0 = x0; v.rd = rd; v.rdy = rdy;
        v.e_valid = ev; v.e_stall = es; v.e_done = ed; v.e_lines = el;
        return v;
    endfunction

    function automatic logic [255:0] mkrec(input logic [63:0] x0, input logic [63:0] x1,
                                           input logic [63:0] x2, input logic [63:0] info,
                                           input logic [7:0] rn);
        return {1'b1, 7'b0, rn, info[47:0], x2, x1, x0};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input logic [8:0] bs);
        start = 1'b1;
        batch_size = bs;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rec(input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2,
                            input logic [63:0] info, input logic [7:0] rn);
        result_valid = 1'b1;
        result_ik_x0 = x0; result_ik_x1 = x1; result_ik_x2 = x2; result_ik_info = info;
        result_read_num = rn;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic send_done(input logic [7:0] rn);
        read_done = 1'b1;
        read_done_num = rn;
        tick();
        read_done = 1'b0;
    endtask

    task automatic pop_line(output logic [511:0] d);
        bit ok;
        ok = 1'b0;
        d = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) begin
                d = out_data;
                ok = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
        chk("pop_line_arrived", ok, 1'b1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 30 && !all_done; i++) tick();
        chk(name, all_done, 1'b1);
    endtask

    vec_t tbl[11];

    initial begin
        logic [511:0] d;
        logic [511:0] held;
        logic [255:0] ra, rb, rc;

        tbl[0]  = mkv(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        tbl[4]  = mkv(1, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[5]  = mkv(0, 0, 1, 7, 0, 0,   0, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 0, 1, 0,   0, 1, 0, 0);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
        tbl[9]  = mkv(0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
        tbl[10] = mkv(0, 0, 1, 5, 0, 0,   0, 0, 1, 1);

        tick(); tick();
        reset_n = 1'b1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_stall", stall_out, 1'b0);
        chk("reset_all_done", all_done, 1'b0);
        chk("reset_lines", lines_written, 16'd0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_err", err, 1'b0);

        // batch_size 0 then a single-record batch, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st; batch_size = tbl[i].bs;
            result_valid = tbl[i].rv; result_ik_x0 = tbl[i].x0; result_read_num = '0;
            read_done = tbl[i].rd; read_done_num = '0; out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_stall", i), stall_out, tbl[i].e_stall);
            chk($sformatf("vec%0d_all_done", i), all_done, tbl[i].e_done);
            chk($sformatf("vec%0d_lines", i), lines_written, tbl[i].e_lines);
        end
        start = 0; result_valid = 0; read_done = 0; out_ready = 0; result_ik_x0 = '0;

        // two records into one line
        start_batch(9'd1);
        chk("two_rec_done_cleared", all_done, 1'b0);
        send_rec(64'd1, 64'd2, 64'd3, 64'd5, 8'd0);
        send_rec(64'd9, 64'd0, 64'd0, 64'd0, 8'd0);
        chk("two_rec_latency", out_valid, 1'b1);
        ra = mkrec(64'd1, 64'd2, 64'd3, 64'd5, 8'd0);
        rb = mkrec(64'd9, 64'd0, 64'd0, 64'd0, 8'd0);
        chk("two_rec_line", out_data, {rb, ra});
        held = out_data;
        tick();
        chk("two_rec_held", out_data, held);
        send_done(8'd0);
        pop_line(d);
        chk("two_rec_popped", d, {rb, ra});
        wait_done("two_rec_all_done");
        chk("two_rec_lines", lines_written, 16'd1);

        // odd record count, partial line flushed at end of batch
        start_batch(9'd2);
        ra = mkrec(64'h11, 64'h0, 64'h0, 64'h0, 8'd0);
        rb = mkrec(64'h22, 64'h0, 64'h0, 64'h0, 8'd1);
        rc = mkrec(64'h33, 64'h0, 64'h0, 64'h0, 8'd1);
        send_rec(64'h11, 0, 0, 0, 8'd0);
        send_rec(64'h22, 0, 0, 0, 8'd1);
        send_rec(64'h33, 0, 0, 0, 8'd1);
        send_done(8'd0);
        send_done(8'd1);
        pop_line(d);
        chk("odd_line0", d, {rb, ra});
        pop_line(d);
        chk("odd_line1", d, {256'd0, rc});
        wait_done("odd_all_done");
        chk("odd_lines", lines_written, 16'd2);

        // back-pressure: four lines queued with the host stalled
        start_batch(9'd1);
        for (int i = 0; i < 4; i++) begin
            send_rec(64'(2 * i + 100), 0, 0, 0, 8'd0);
            send_rec(64'(2 * i + 101), 0, 0, 0, 8'd0);
            chk($sformatf("bp_stall_after_%0d_lines", i + 1), stall_out, (i >= 1));
        end
        chk("bp_no_overflow", overflow, 1'b0);
        send_done(8'd0);
        for (int i = 0; i < 4; i++) begin
            pop_line(d);
            chk($sformatf("bp_line%0d", i), d,
                {mkrec(64'(2 * i + 101), 0, 0, 0, 8'd0), mkrec(64'(2 * i + 100), 0, 0, 0, 8'd0)});
        end
        wait_done("bp_all_done");
        chk("bp_lines", lines_written, 16'd4);

        // overflow: fifth line dropped, first four intact
        start_batch(9'd1);
        for (int i = 0; i < 5; i++) begin
            send_rec(64'(2 * i + 200), 0, 0, 0, 8'd0);
            send_rec(64'(2 * i + 201), 0, 0, 0, 8'd0);
        end
        chk("ovf_set", overflow, 1'b1);
        send_done(8'd0);
        for (int i = 0; i < 4; i++) begin
            pop_line(d);
            chk($sformatf("ovf_line%0d", i), d,
                {mkrec(64'(2 * i + 201), 0, 0, 0, 8'd0), mkrec(64'(2 * i + 200), 0, 0, 0, 8'd0)});
        end
        wait_done("ovf_all_done");
        chk("ovf_lines", lines_written, 16'd4);
        chk("ovf_sticky", overflow, 1'b1);

        // last record and final read_done in the same cycle
        start_batch(9'd1);
        chk("sim_ovf_cleared", overflow, 1'b0);
        read_done = 1'b1; read_done_num = 8'd0;
        send_rec(64'hA1, 64'hA2, 64'hA3, 64'h7, 8'd0);
        read_done = 1'b0;
        pop_line(d);
        chk("sim_flushed_line", d, {256'd0, mkrec(64'hA1, 64'hA2, 64'hA3, 64'h7, 8'd0)});
        wait_done("sim_all_done");

        // duplicate read_done
        start_batch(9'd4);
        send_done(8'd3);
        send_done(8'd3);
        chk("dup_err", err, CHK);
        send_done(8'd0);
        send_done(8'd1);
        repeat (6) tick();
        chk("dup_not_done_early", all_done, !CHK);
        if (CHK) send_done(8'd2);
        wait_done("dup_all_done");
        start_batch(9'd0);
        chk("err_cleared_by_start", err, 1'b0);
        wait_done("empty_batch_done");

        // reset mid-batch discards queued and partial lines
        start_batch(9'd1);
        send_rec(64'h51, 0, 0, 0, 8'd0);
        send_rec(64'h52, 0, 0, 0, 8'd0);
        send_rec(64'h53, 0, 0, 0, 8'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_all_done", all_done, 1'b0);
        start_batch(9'd0);
        wait_done("midrst_batch_done");
        chk("midrst_no_lines", lines_written, 16'd0);
        chk("midrst_fifo_empty", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/smem_result_writer.md
# smem_result_writer

Output-side counterpart of the read loader. It collects SMEM results from the pipeline and packs two 256-bit result records into each 512-bit cache line. Completed lines are buffered in a small line FIFO and presented to the host write port with a valid/ready handshake. The block back-pressures the pipeline through `stall_out`, tracks per-read completion against `batch_size`, and flushes a partial line at end of batch.

## Interface
- `DEPTH`, 4: line FIFO depth in 512-bit lines; power of two, ≥ 4.
- `SKID`, 2: `stall_out` asserts when free FIFO slots ≤ `SKID`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; latches `batch_size`, begins a batch.
- `batch_size`  in  9  reads in batch, 0..256.
- `result_valid`  in  1  result record present this cycle.
- `result_read_num`  in  8  read number of the record.
- `result_ik_x0`, `result_ik_x1`, `result_ik_x2`, `result_ik_info`  in  64 each  SMEM interval.
- `read_done`  in  1  pulse: read `read_done_num` has emitted its last result.
- `read_done_num`  in  8  read number for `read_done`.
- `stall_out`  out  1  back-pressure to the pipeline.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  host accepts the head line.
- `out_data`  out  512  FIFO head line.
- `lines_written`  out  16  lines accepted by the host in this batch (write address).
- `all_done`  out  1  batch complete, all lines accepted.
- `overflow`  out  1  sticky: a line was dropped because the FIFO was full.
- `err`  out  1  sticky: format check failure; see Configuration.

## Operation
- **Record layout (256 b):**
  - [63:0] = x0; [127:64] = x1; [191:128] = x2.
  - [239:192] = info[47:0]; [247:240] = read_num; [254:248] = 0.
  - [255] = 1 (record valid).
  - info[63:48] is zero by construction and is dropped.
- **Line layout:** slot0 = [255:0] (older record), slot1 = [511:256]. An empty slot is all zeros.
- **Packing:**
  - A `result_valid` with slot0 empty stores the record in slot0.
  - A `result_valid` with slot0 full pushes {new record, slot0} to the FIFO and clears slot0.
  - If the FIFO is full at the push, the line is dropped and `overflow` sets.
- **FSM:**
  - IDLE: on `start`, latch `batch_size`, clear `done_cnt`, `lines_written`, `overflow` and `err`; go to RUN.
  - RUN: accept results and `read_done`. When `done_cnt == batch_size`, go to FLUSH.
  - FLUSH: if slot0 is occupied, push {256'b0, slot0} when the FIFO is not full, stalling otherwise; then go to DRAIN. If slot0 is empty, go straight to DRAIN.
  - DRAIN: wait for the FIFO to be empty, then go to DONE.
  - DONE: `all_done` = 1. `start` re-enters RUN (same actions as from IDLE).
- `result_valid` and `read_done` in the same cycle: the record is packed first; the completion check uses the updated count, so the flush occurs the following cycle.
- `result_valid` outside RUN is ignored. `read_done` outside RUN is ignored.
- A FIFO push and pop in the same cycle keep the count unchanged. This is legal when the FIFO is full, provided `out_ready` is high.
- `start` during RUN, FLUSH or DRAIN is ignored.

## Timing
- **Reset values:** all outputs 0, `out_data` = 0; FSM in IDLE; FIFO empty; slot0 empty.
- **Latency:** second record at edge N; `out_valid` = 1 in cycle N+1 if the FIFO was empty.
- `out_data` is the registered FIFO head. It is held stable while `out_valid && !out_ready`.
- **Transfer:** occurs when `out_valid && out_ready`; `lines_written` increments on that edge.
- `stall_out` = (DEPTH − count ≤ SKID) || state == FLUSH. It is combinational from registered state.
- The pipeline may present at most one record per cycle for up to `SKID` − 1 cycles after `stall_out` rises.
- **Reset mid-batch:** FIFO contents and the partial line are discarded; the block returns to IDLE.
- `batch_size` = 0: RUN → FLUSH → DRAIN → DONE, no lines, `all_done` in cycle 4 after `start`.

## Configuration
- `SMEM_RESULT_CHECK_EN` defined:
  - `err` sets when an accepted record has info[63:48] ≠ 0.
  - `err` sets when `read_done_num` ≥ the latched `batch_size`.
  - `err` sets when a `read_done` arrives for an already-completed read (per-read 256-bit done bitmap).
  - A duplicate `read_done` does not increment `done_cnt`.
- `SMEM_RESULT_CHECK_EN` undefined: no bitmap, `err` tied to 0, every `read_done` increments `done_cnt`.

## Structure
- The shared package holds:
  - Constants CL = 512, READ_NUM_WIDTH = 8, MAX_READ = 256, REC_W = 256.
  - The record field bit offsets.
  - The FSM state enum (IDLE, RUN, FLUSH, DRAIN, DONE).
- One natural sub-module: `line_fifo` (parameterised width/depth, registered head, count output).

## Test plan
- **Two records:** `start` (batch_size = 1); records for read 0 (x0 = 1, x1 = 2, x2 = 3, info = 5) and read 0 (x0 = 9), then `read_done` 0.
  - One line: [63:0] = 1, [255] = 1, [319:256] = 9, [511] = 1.
  - `all_done` after the host accepts it; `lines_written` = 1.
- **Odd count flush:** three records, then `read_done` for both reads of batch_size = 2.
  - Second line has slot1 = 0.
  - `lines_written` = 2.
- **Back-pressure:** DEPTH = 4, `out_ready` = 0, records streamed.
  - `stall_out` rises after 2 lines are queued.
  - Holding off input: no `overflow`, 4 lines delivered in order.
- **Overflow:** ignore `stall_out`, keep `out_ready` = 0, push 5 lines → `overflow` = 1, first 4 lines intact.
- **Simultaneous:** last record and final `read_done` in the same cycle → the record appears in the flushed line.
- **Check build:**
  - Duplicate `read_done` 3 → `err` = 1, `all_done` is not reached early.
  - Without the macro, `err` stays 0.
